// File: rtl/hi_speed_sampler_capture_ctrl.sv
// Capture sequencer: pre-trigger fill, trigger arm/detect, post-trigger fill, done/irq reporting.
// Optional build macro SAMPLER_TIMESTAMP_EN adds a free-running cycle counter and trig_ts output.
module hi_speed_sampler_capture_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pre_cnt,
  input  logic [ADDR_W-1:0] post_cnt,
  input  logic              trig_edge,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_trig,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              busy,
  output logic              done,
  output logic              irq,
  output logic              cfg_err,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [1:0]        state
`ifdef SAMPLER_TIMESTAMP_EN
  ,
  output logic [31:0]       trig_ts
`endif
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPre   = 2'd1,
    StArmed = 2'd2,
    StPost  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   pre_q, pre_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic                trig_prev_q, trig_prev_d;
  logic                done_d, cfg_err_d, irq_d, we_d;
  logic [ADDR_W-1:0]   addr_d, trig_addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [ADDR_W:0]     cfg_sum;
  logic [ADDR_W-1:0]   pre_inc;
  logic                trig_fire;

  // MSB of the widened sum set means pre_cnt+post_cnt >= DEPTH
  assign cfg_sum = {1'b0, pre_cnt} + {1'b0, post_cnt};
  assign pre_inc = pre_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    pre_d       = pre_q;
    rem_d       = rem_q;
    trig_prev_d = trig_prev_q;
    done_d      = done;
    cfg_err_d   = cfg_err;
    irq_d       = 1'b0;
    we_d        = 1'b0;
    addr_d      = buf_addr;
    wdata_d     = buf_wdata;
    trig_addr_d = trig_addr;
    trig_fire   = 1'b0;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_sum[ADDR_W]) begin
              cfg_err_d = 1'b1;
            end else begin
              done_d      = 1'b0;
              cfg_err_d   = 1'b0;
              wptr_d      = '0;
              trig_prev_d = 1'b0;
              pre_d       = '0;
              state_d     = (pre_cnt == '0) ? StArmed : StPre;
            end
          end
        end
        StPre: begin
          if (s_valid) begin
            trig_prev_d = s_trig;
            pre_d       = (pre_q == pre_cnt) ? pre_q : pre_inc;
            if (pre_inc == pre_cnt) state_d = StArmed;
          end
        end
        StArmed: begin
          if (s_valid) begin
            trig_prev_d = s_trig;
            trig_fire   = s_trig && (!trig_edge || !trig_prev_q);
            if (trig_fire) begin
              trig_addr_d = wptr_q;
              if (post_cnt == '0) begin
                state_d = StIdle;
                done_d  = 1'b1;
                irq_d   = 1'b1;
              end else begin
                rem_d   = post_cnt;
                state_d = StPost;
              end
            end
          end
        end
        StPost: begin
          if (s_valid) begin
            rem_d = rem_q - ADDR_W'(1);
            if (rem_q == ADDR_W'(1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
              irq_d   = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      // Every sample seen while capturing is written, including the one that completes it
      if (s_valid && state_q != StIdle) begin
        we_d    = 1'b1;
        addr_d  = wptr_q;
        wdata_d = s_data;
        wptr_d  = wptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      pre_q       <= '0;
      rem_q       <= '0;
      trig_prev_q <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      irq         <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      trig_addr   <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      pre_q       <= pre_d;
      rem_q       <= rem_d;
      trig_prev_q <= trig_prev_d;
      done        <= done_d;
      cfg_err     <= cfg_err_d;
      irq         <= irq_d;
      buf_we      <= we_d;
      buf_addr    <= addr_d;
      buf_wdata   <= wdata_d;
      trig_addr   <= trig_addr_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign state = state_q;

`ifdef SAMPLER_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ts_q    <= '0;
      trig_ts <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (trig_fire) trig_ts <= ts_q;
    end
  end
`endif

endmodule

// File: tb/tb_hi_speed_sampler_capture_ctrl.sv
// Directed bench for hi_speed_sampler_capture_ctrl: table of capture scenarios plus
// hand-written abort/reset/config-error sequences.
module tb_hi_speed_sampler_capture_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] pre_cnt = '0;
  logic [ADDR_W-1:0] post_cnt = '0;
  logic              trig_edge = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_trig = 1'b0;
  logic              buf_we, busy, done, irq, cfg_err;
  logic [ADDR_W-1:0] buf_addr, trig_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [1:0]        state;
`ifdef SAMPLER_TIMESTAMP_EN
  logic [31:0]       trig_ts;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  hi_speed_sampler_capture_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .start    (start),
    .abort    (abort),
    .pre_cnt  (pre_cnt),
    .post_cnt (post_cnt),
    .trig_edge(trig_edge),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_trig   (s_trig),
    .buf_we   (buf_we),
    .buf_addr (buf_addr),
    .buf_wdata(buf_wdata),
    .busy     (busy),
    .done     (done),
    .irq      (irq),
    .cfg_err  (cfg_err),
    .trig_addr(trig_addr),
    .state    (state)
`ifdef SAMPLER_TIMESTAMP_EN
    ,
    .trig_ts  (trig_ts)
`endif
  );

  typedef struct {
    int pre;
    int post;
    bit edge_m;
    int trig_at;
    int exp_writes;
    int exp_trig_addr;
    int exp_last_addr;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [31:0] data_of(int i);
    return 32'hA5C3_0000 ^ i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_buf_we"}, 32'(buf_we), 0);
    check({tag, "_buf_addr"}, 32'(buf_addr), 0);
    check({tag, "_buf_wdata"}, buf_wdata, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_irq"}, 32'(irq), 0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 0);
    check({tag, "_trig_addr"}, 32'(trig_addr), 0);
    check({tag, "_state"}, 32'(state), 0);
  endtask

  task automatic do_start(input int pre, input int post, input bit edge_m, input bit with_abort);
    @(negedge ACLK);
    start = 1'b1; abort = with_abort; pre_cnt = ADDR_W'(pre); post_cnt = ADDR_W'(post);
    trig_edge = edge_m; s_valid = 1'b0; s_trig = 1'b0;
    @(negedge ACLK);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nwr, irqs, last;
    bit addr_ok, data_ok;
    string t;
    t = $sformatf("vec%0d", idx);
    do_start(v.pre, v.post, v.edge_m, 1'b0);
    check({t, "_busy_start"}, 32'(busy), 1);
    nwr = 0; irqs = 0; last = -1; addr_ok = 1'b1; data_ok = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      s_valid = 1'b1; s_data = data_of(i); s_trig = (i >= v.trig_at);
      @(negedge ACLK);
      if (buf_we) begin
        if (32'(buf_addr) != nwr % DEPTH) addr_ok = 1'b0;
        if (buf_wdata != data_of(nwr)) data_ok = 1'b0;
        last = int'(buf_addr);
        nwr++;
      end
      if (irq) irqs++;
    end
    check({t, "_done"}, 32'(done), 1);
    check({t, "_writes"}, 32'(nwr), 32'(v.exp_writes));
    check({t, "_trig_addr"}, 32'(trig_addr), 32'(v.exp_trig_addr));
    check({t, "_last_addr"}, 32'(last), 32'(v.exp_last_addr));
    check({t, "_irq_pulses"}, 32'(irqs), 1);
    check({t, "_addr_seq"}, 32'(addr_ok), 1);
    check({t, "_data_seq"}, 32'(data_ok), 1);
    check({t, "_busy_end"}, 32'(busy), 0);
    check({t, "_state_end"}, 32'(state), 0);
    // Samples after completion must not reach the buffer
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    @(negedge ACLK);
    check({t, "_no_write_after"}, 32'(buf_we), 0);
    check({t, "_irq_single"}, 32'(irq), 0);
    check({t, "_done_sticky"}, 32'(done), 1);
    s_valid = 1'b0; s_trig = 1'b0;
  endtask

  initial begin
    int nwr;
    vecs[0] = '{pre: 4,    post: 3,  edge_m: 1'b1, trig_at: 10,
                exp_writes: 14,   exp_trig_addr: 10,   exp_last_addr: 13};
    vecs[1] = '{pre: 1000, post: 20, edge_m: 1'b1, trig_at: 1010,
                exp_writes: 1031, exp_trig_addr: 1010, exp_last_addr: 6};
    vecs[2] = '{pre: 8,    post: 2,  edge_m: 1'b0, trig_at: 0,
                exp_writes: 11,   exp_trig_addr: 8,    exp_last_addr: 10};
    vecs[3] = '{pre: 0,    post: 0,  edge_m: 1'b0, trig_at: 0,
                exp_writes: 1,    exp_trig_addr: 0,    exp_last_addr: 0};

    repeat (3) @(negedge ACLK);
    check_all_zero("reset");
    ARESET = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k], k);

    // Oversized window: rejected, no capture
    do_start(600, 500, 1'b0, 1'b0);
    check("cfg_err_set", 32'(cfg_err), 1);
    check("cfg_err_state", 32'(state), 0);
    nwr = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_trig = 1'b1; @(negedge ACLK);
      if (buf_we) nwr++;
    end
    check("cfg_err_no_write", 32'(nwr), 0);
    s_valid = 1'b0; s_trig = 1'b0;

    // Edge mode with trigger held high from the first sample never fires
    do_start(8, 2, 1'b1, 1'b0);
    check("edge_cfg_err_cleared", 32'(cfg_err), 0);
    check("edge_done_cleared", 32'(done), 0);
    for (int i = 0; i < 30; i++) begin
      s_valid = 1'b1; s_trig = 1'b1; @(negedge ACLK);
    end
    check("edge_still_armed", 32'(state), 2);
    check("edge_no_done", 32'(done), 0);
    abort = 1'b1; @(negedge ACLK); abort = 1'b0;
    check("edge_abort_state", 32'(state), 0);
    check("edge_abort_done", 32'(done), 0);
    check("edge_abort_busy", 32'(busy), 0);
    check("edge_abort_no_write", 32'(buf_we), 0);
    s_valid = 1'b0; s_trig = 1'b0;

    // Abort during POST with a sample present
    do_start(0, 10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_trig = (i == 0); @(negedge ACLK);
    end
    check("post_state", 32'(state), 3);
    abort = 1'b1; s_valid = 1'b1; @(negedge ACLK); abort = 1'b0;
    check("post_abort_no_write", 32'(buf_we), 0);
    check("post_abort_state", 32'(state), 0);
    check("post_abort_done", 32'(done), 0);
    check("post_abort_irq", 32'(irq), 0);
    s_valid = 1'b0;

    // start and abort together: no capture
    do_start(2, 2, 1'b0, 1'b1);
    check("start_abort_busy", 32'(busy), 0);
    s_valid = 1'b1; @(negedge ACLK);
    check("start_abort_no_write", 32'(buf_we), 0);
    check("start_abort_state", 32'(state), 0);
    s_valid = 1'b0;

    // Reset in the middle of PRE with a sample pending
    do_start(50, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = data_of(i); @(negedge ACLK);
    end
    check("pre_state", 32'(state), 1);
    ARESET = 1'b1; s_valid = 1'b1; s_data = 32'h1234_5678; @(negedge ACLK);
    check_all_zero("midpre_reset");
    s_valid = 1'b0;

`ifdef SAMPLER_TIMESTAMP_EN
    check("ts_reset", trig_ts, 0);
    // Release reset so the next rising edge is cycle 0; start is sampled on cycle 0
    ARESET = 1'b0; start = 1'b1; pre_cnt = '0; post_cnt = '0; trig_edge = 1'b0;
    for (int k = 1; k <= 57; k++) begin
      @(negedge ACLK);
      start = 1'b0; s_valid = 1'b1; s_trig = (k == 57);
    end
    @(negedge ACLK);
    s_valid = 1'b0; s_trig = 1'b0;
    check("ts_done", 32'(done), 1);
    check("ts_value", trig_ts, 57);
`else
    ARESET = 1'b0;
`endif

    repeat (2) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
